fios_operand_server: RTL and testbench
======================================

Name: fios_operand_server

Overview:
- Responder-side companion to the cascaded FIOS Montgomery multiplier.
- Holds operands A, B, P in s-word x 17-bit local memories, loaded by the host, and serves them on the multiplier's fetch/shift requests.
- Issues the multiplier start pulse, captures pushed result words into a result memory, and reports completion and protocol errors to the host.
- Sits between the host/bus adapter and the multiplier top level, one instance per multiplier.

Parameters:
- s, 8, number of 17-bit words per operand.
- PE_NB, 8, number of processing elements; width of the parallel A window. Must satisfy 1 <= PE_NB <= s.
- AW, $clog2(s), word address width (localparam).
- NG, (s+PE_NB-1)/PE_NB, number of A groups (localparam).

Ports:
- clock_i  in  1  single clock.
- reset_i  in  1  synchronous, active-high reset.
- op_we_i  in  1  host operand write strobe.
- op_sel_i  in  2  memory select: 0=A, 1=B, 2=P, 3=ignored.
- op_addr_i  in  AW  operand word address.
- op_data_i  in  17  operand word.
- start_i  in  1  host start request.
- busy_o  out  1  high from accepted start until done_o.
- mm_start_o  out  1  one-cycle start pulse to the multiplier.
- a_shift_i  in  1  multiplier request for the next A group.
- b_fetch_i  in  1  multiplier request for the next B word.
- p_fetch_i  in  1  multiplier request for the next P word.
- res_push_i  in  1  multiplier result word valid.
- res_i  in  17  multiplier result word.
- mm_done_i  in  1  multiplier completion.
- a_o  out  PE_NB*17  A window; word j in bits [17j+16:17j].
- b_o  out  17  current B word (registered).
- p_o  out  17  current P word (registered).
- res_addr_i  in  AW  host result read address.
- res_rdata_o  out  17  result word at res_addr_i, registered, 1-cycle read latency.
- done_o  out  1  one-cycle completion pulse.
- error_o  out  1  sticky protocol error; cleared by reset or by an accepted start.

Behaviour:
- Reset: state=IDLE; busy_o, mm_start_o, done_o, error_o = 0; a_o, b_o, p_o, res_rdata_o = 0; all pointers = 0. Operand and result memories are not cleared.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE: op_we_i writes the selected memory at op_addr_i; sel=3 is a no-op. start_i moves to LOAD.
  - LOAD (1 cycle): a_o <= A[0..PE_NB-1]; grp=1; b_ptr=p_ptr=res_ptr=0; error_o cleared; mm_start_o=1 (registered, asserted during LOAD); next state RUN.
  - RUN: services requests. mm_done_i moves to DONE.
  - DONE (1 cycle): done_o=1; next state IDLE.
- busy_o = 1 in LOAD, RUN and DONE.
- While busy_o=1, start_i and op_we_i are ignored.
- B/P service:
  - b_fetch_i at cycle t gives b_o=B[b_ptr] at t+1; b_ptr increments and wraps s-1 -> 0, because B is re-streamed each outer iteration.
  - P service is identical and independent. Simultaneous b_fetch_i and p_fetch_i are both serviced.
  - Fetches outside RUN are ignored.
- A service:
  - a_shift_i in RUN at t gives a_o word j = A[grp*PE_NB+j] at t+1, or 0 when the index >= s; then grp increments.
  - Once grp = NG, further shifts present all zeros; grp saturates. This is not an error, because the multiplier shifts after its final iteration.
- Results:
  - res_push_i in RUN writes res_i to RES[res_ptr]; res_ptr increments.
  - A push with res_ptr = s is dropped and sets error_o.
  - Pushes outside RUN are ignored.
- Errors: mm_done_i with res_ptr != s sets error_o; DONE still follows.
- Simultaneous events: res_push_i and mm_done_i in the same cycle store the word first, then check the count (count includes that word).
- Result read: RES is readable in any state; a host read of an address being written in the same cycle returns the old data.
- Reset mid-operation returns to IDLE in one cycle; no done_o is issued.
- Target size: 180-300 lines of RTL (three s-deep memories plus the result memory, two wrap counters, a saturating group counter, 4-state FSM).

Test Plan:
- s=8, PE_NB=3. Load A[k]=0x100+k, B[k]=0x200+k, P[k]=0x300+k. Pulse start_i. Expect mm_start_o high exactly 1 cycle, one cycle after start_i, with a_o={0x102,0x101,0x100}. Then three a_shift_i pulses give {0x105,0x104,0x103}, {0,0x107,0x106}, {0,0,0}.
- In RUN, issue 10 b_fetch_i pulses. Expect b_o sequence 0x200..0x207,0x200,0x201, each one cycle after its request. Issue b_fetch_i and p_fetch_i in the same cycle: both advance.
- Push res_i = 0x1A000+k for k=0..7, then mm_done_i. Expect done_o pulse 1 cycle later, busy_o low the cycle after, error_o=0. Reading res_addr_i=5 returns 0x1A005 one cycle later.
- Push 9 words. Expect the 9th dropped, error_o=1, RES[0..7] intact. Next accepted start clears error_o.
- Issue mm_done_i after 6 pushes. Expect error_o=1 and done_o still pulses.
- Assert reset_i mid-RUN. Expect the next cycle busy_o=0, a_o=b_o=p_o=0, no done_o. Operand memories are retained: a new start gives a_o={0x102,0x101,0x100}. op_we_i while busy leaves memory unchanged.

Source files
------------

// File: rtl/fios_operand_server.sv
// fios_operand_server
//   Responder-side companion to the cascaded FIOS Montgomery multiplier.
//   The host loads operands A, B and P (s words of 17 bits each) while the
//   block is idle. A host start then launches the multiplier. While the
//   multiplier runs, this block serves its A-window shifts and its B/P word
//   fetches, and it captures the result words the multiplier pushes back.
//   It reports completion and any protocol error to the host.
//
// Ports
//   clock_i, reset_i           clock; synchronous active-high reset
//   op_we_i/op_sel_i/
//   op_addr_i/op_data_i        host operand write (sel 0=A 1=B 2=P 3=none)
//   start_i, busy_o            host start request, busy indication
//   done_o, error_o            completion pulse, sticky protocol error
//   res_addr_i, res_rdata_o    host result read port (1-cycle latency)
//   mm_start_o                 start pulse to the multiplier
//   a_shift_i, a_o             next-A-group request, PE_NB-word A window
//   b_fetch_i, b_o             next-B-word request, current B word
//   p_fetch_i, p_o             next-P-word request, current P word
//   res_push_i, res_i          result word push from the multiplier
//   mm_done_i                  multiplier completion
//
// Handshake: every request input (a_shift_i, b_fetch_i, p_fetch_i,
//   res_push_i, mm_done_i) is a single-cycle strobe with no back-pressure.
//   A request is acted on in the cycle it is high, and only in RUN.
//   Served data appears on the outputs the following cycle.
module fios_operand_server #(
   parameter  int s     = 8,
   parameter  int PE_NB = 8,
   localparam int AW    = (s > 1) ? $clog2(s) : 1,
   localparam int NG    = (s + PE_NB - 1) / PE_NB
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  op_we_i,
   input  logic [1:0]            op_sel_i,
   input  logic [AW-1:0]         op_addr_i,
   input  logic [16:0]           op_data_i,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  mm_start_o,
   input  logic                  a_shift_i,
   input  logic                  b_fetch_i,
   input  logic                  p_fetch_i,
   input  logic                  res_push_i,
   input  logic [16:0]           res_i,
   input  logic                  mm_done_i,
   output logic [PE_NB*17-1:0]   a_o,
   output logic [16:0]           b_o,
   output logic [16:0]           p_o,
   input  logic [AW-1:0]         res_addr_i,
   output logic [16:0]           res_rdata_o,
   output logic                  done_o,
   output logic                  error_o
);

   localparam int             GW       = $clog2(NG + 1);
   localparam logic [AW:0]    RES_FULL = (AW+1)'(s);
   localparam logic [AW-1:0]  LAST     = AW'(s - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t               r_state, w_state_nxt;

   logic [16:0]          r_mem_a   [0:s-1];
   logic [16:0]          r_mem_b   [0:s-1];
   logic [16:0]          r_mem_p   [0:s-1];
   logic [16:0]          r_mem_res [0:s-1];

   logic [PE_NB*17-1:0]  r_a;
   logic [16:0]          r_b, r_p, r_res_rdata;
   logic [GW-1:0]        r_grp;
   logic [AW-1:0]        r_b_ptr, r_p_ptr;
   logic [AW:0]          r_res_ptr;
   logic                 r_err;

   logic                 w_start_acc, w_run, w_push_ok, w_push_ovf, w_done_bad;
   logic [AW:0]          w_res_cnt;
   logic [GW-1:0]        w_grp_sel;
   logic [PE_NB*17-1:0]  w_a_win;

   // ---------------- FSM ----------------
   always_ff @(posedge clock_i) begin
      if (reset_i) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy_o      = 1'b1;
      mm_start_o  = 1'b0;
      done_o      = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy_o = 1'b0;
            if (start_i) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            mm_start_o  = 1'b1;
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (mm_done_i) w_state_nxt = S_DONE;
         end
         default: begin
            done_o      = 1'b1;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------- control decode ----------------
   assign w_start_acc = (r_state == S_IDLE) && start_i;
   assign w_run       = (r_state == S_RUN);
   assign w_push_ok   = w_run && res_push_i && (r_res_ptr != RES_FULL);
   assign w_push_ovf  = w_run && res_push_i && (r_res_ptr == RES_FULL);
   // A push and a done in the same cycle: the pushed word counts.
   assign w_res_cnt   = r_res_ptr + ((AW+1)'(w_push_ok));
   assign w_done_bad  = w_run && mm_done_i && (w_res_cnt != RES_FULL);

   // The window for group 0 is loaded on the start edge, so it is already
   // valid while mm_start_o is high.
   assign w_grp_sel = w_start_acc ? '0 : r_grp;

   // A group window. Indices past the end read as zero. This also covers a
   // saturated group counter, because NG*PE_NB >= s.
   always_comb begin
      w_a_win = '0;
      for (int j = 0; j < PE_NB; j++) begin
         if ((int'(w_grp_sel) * PE_NB + j) < s)
            w_a_win[17*j +: 17] = r_mem_a[AW'(int'(w_grp_sel) * PE_NB + j)];
      end
   end

   // ---------------- serving datapath ----------------
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_a       <= '0;
         r_b       <= '0;
         r_p       <= '0;
         r_grp     <= '0;
         r_b_ptr   <= '0;
         r_p_ptr   <= '0;
         r_res_ptr <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_start_acc) begin
            r_a       <= w_a_win;
            r_grp     <= GW'(1);
            r_b_ptr   <= '0;
            r_p_ptr   <= '0;
            r_res_ptr <= '0;
            r_err     <= 1'b0;
         end
         if (w_run) begin
            if (a_shift_i) begin
               r_a <= w_a_win;
               // Saturate: the multiplier shifts once more after its last group.
               if (r_grp != GW'(NG)) r_grp <= r_grp + GW'(1);
            end
            // B and P are re-streamed every outer iteration, so the pointers wrap.
            if (b_fetch_i) begin
               r_b     <= r_mem_b[r_b_ptr];
               r_b_ptr <= (r_b_ptr == LAST) ? '0 : r_b_ptr + AW'(1);
            end
            if (p_fetch_i) begin
               r_p     <= r_mem_p[r_p_ptr];
               r_p_ptr <= (r_p_ptr == LAST) ? '0 : r_p_ptr + AW'(1);
            end
            if (w_push_ok) r_res_ptr <= r_res_ptr + (AW+1)'(1);
            if (w_push_ovf || w_done_bad) r_err <= 1'b1;
         end
      end
   end

   // ---------------- memories (deliberately not reset) ----------------
   always_ff @(posedge clock_i) begin
      if ((r_state == S_IDLE) && op_we_i && ({1'b0, op_addr_i} < RES_FULL)) begin
         case (op_sel_i)
            2'd0:    r_mem_a[op_addr_i] <= op_data_i;
            2'd1:    r_mem_b[op_addr_i] <= op_data_i;
            2'd2:    r_mem_p[op_addr_i] <= op_data_i;
            default: ;
         endcase
      end
      if (w_push_ok) r_mem_res[r_res_ptr[AW-1:0]] <= res_i;
   end

   // Read-before-write: a read colliding with a push returns the old word.
   always_ff @(posedge clock_i) begin
      if (reset_i) r_res_rdata <= '0;
      else         r_res_rdata <= r_mem_res[res_addr_i];
   end

   assign a_o         = r_a;
   assign b_o         = r_b;
   assign p_o         = r_p;
   assign res_rdata_o = r_res_rdata;
   assign error_o     = r_err;

endmodule

// File: tb/tb_fios_operand_server.sv
// Directed testbench for fios_operand_server (s=8, PE_NB=3).
module tb_fios_operand_server;

   localparam int S  = 8;
   localparam int PE = 3;
   localparam int AW = 3;

   logic              clk = 1'b0;
   logic              reset_i = 1'b1;
   logic              op_we_i = 1'b0;
   logic [1:0]        op_sel_i = '0;
   logic [AW-1:0]     op_addr_i = '0;
   logic [16:0]       op_data_i = '0;
   logic              start_i = 1'b0;
   logic              busy_o, mm_start_o, done_o, error_o;
   logic              a_shift_i = 1'b0, b_fetch_i = 1'b0, p_fetch_i = 1'b0;
   logic              res_push_i = 1'b0, mm_done_i = 1'b0;
   logic [16:0]       res_i = '0;
   logic [PE*17-1:0]  a_o;
   logic [16:0]       b_o, p_o, res_rdata_o;
   logic [AW-1:0]     res_addr_i = '0;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   fios_operand_server #(.s(S), .PE_NB(PE)) dut (
      .clock_i(clk), .reset_i(reset_i),
      .op_we_i(op_we_i), .op_sel_i(op_sel_i), .op_addr_i(op_addr_i), .op_data_i(op_data_i),
      .start_i(start_i), .busy_o(busy_o), .mm_start_o(mm_start_o),
      .a_shift_i(a_shift_i), .b_fetch_i(b_fetch_i), .p_fetch_i(p_fetch_i),
      .res_push_i(res_push_i), .res_i(res_i), .mm_done_i(mm_done_i),
      .a_o(a_o), .b_o(b_o), .p_o(p_o),
      .res_addr_i(res_addr_i), .res_rdata_o(res_rdata_o),
      .done_o(done_o), .error_o(error_o)
   );

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] sel, input logic [AW-1:0] addr, input logic [16:0] data);
      op_we_i = 1'b1; op_sel_i = sel; op_addr_i = addr; op_data_i = data;
      tick();
      op_we_i = 1'b0;
   endtask

   // Start pulse, then step through LOAD into RUN.
   task automatic launch();
      start_i = 1'b1; tick(); start_i = 1'b0;
      tick();
   endtask

   task automatic push(input logic [16:0] w, input logic with_done);
      res_push_i = 1'b1; res_i = w; mm_done_i = with_done;
      tick();
      res_push_i = 1'b0; mm_done_i = 1'b0;
   endtask

   initial begin
      // ---- reset ----
      tick(); tick();
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_mm_start", 64'(mm_start_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_error", 64'(error_o), 64'd0);
      chk("rst_a", 64'(a_o), 64'd0);
      chk("rst_b", 64'(b_o), 64'd0);
      chk("rst_p", 64'(p_o), 64'd0);
      chk("rst_rdata", 64'(res_rdata_o), 64'd0);
      reset_i = 1'b0;
      tick();

      // ---- load operands; sel=3 must not touch anything ----
      for (int k = 0; k < S; k++) begin
         wr(2'd0, AW'(k), 17'h100 + 17'(k));
         wr(2'd1, AW'(k), 17'h200 + 17'(k));
         wr(2'd2, AW'(k), 17'h300 + 17'(k));
      end
      wr(2'd3, 3'd0, 17'h1FFFF);

      // ---- start: mm_start one cycle after start_i, with window 0 ----
      start_i = 1'b1; tick(); start_i = 1'b0;
      chk("load_mm_start", 64'(mm_start_o), 64'd1);
      chk("load_busy", 64'(busy_o), 64'd1);
      chk("load_a_win0", 64'(a_o), 64'({17'h102, 17'h101, 17'h100}));
      tick();
      chk("run_mm_start_low", 64'(mm_start_o), 64'd0);
      chk("run_a_win0_hold", 64'(a_o), 64'({17'h102, 17'h101, 17'h100}));

      // host write and start while busy must be ignored
      op_we_i = 1'b1; op_sel_i = 2'd0; op_addr_i = 3'd0; op_data_i = 17'h0AA; start_i = 1'b1;
      tick();
      op_we_i = 1'b0; start_i = 1'b0;
      chk("busy_start_ignored", 64'(mm_start_o), 64'd0);

      // ---- A shifts, including saturation past the last group ----
      a_shift_i = 1'b1; tick();
      chk("a_win1", 64'(a_o), 64'({17'h105, 17'h104, 17'h103}));
      tick();
      chk("a_win2", 64'(a_o), 64'({17'h000, 17'h107, 17'h106}));
      tick();
      chk("a_win3_zero", 64'(a_o), 64'd0);
      tick();
      chk("a_win_sat_zero", 64'(a_o), 64'd0);
      a_shift_i = 1'b0;

      // ---- 10 B fetches, wrapping after word 7 ----
      b_fetch_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("b_seq%0d", i), 64'(b_o), 64'(17'h200 + 17'(i % 8)));
      end
      b_fetch_i = 1'b0;
      tick();
      chk("b_hold", 64'(b_o), 64'h201);

      // P alone, then B and P together
      p_fetch_i = 1'b1; tick(); p_fetch_i = 1'b0;
      chk("p_first", 64'(p_o), 64'h300);
      b_fetch_i = 1'b1; p_fetch_i = 1'b1; tick(); b_fetch_i = 1'b0; p_fetch_i = 1'b0;
      chk("bp_both_b", 64'(b_o), 64'h202);
      chk("bp_both_p", 64'(p_o), 64'h301);

      // ---- normal completion: 8 pushes then done ----
      for (int k = 0; k < S; k++) push(17'h1A000 + 17'(k), 1'b0);
      mm_done_i = 1'b1; tick(); mm_done_i = 1'b0;
      chk("ok_done_pulse", 64'(done_o), 64'd1);
      chk("ok_busy_in_done", 64'(busy_o), 64'd1);
      tick();
      chk("ok_done_low", 64'(done_o), 64'd0);
      chk("ok_busy_low", 64'(busy_o), 64'd0);
      chk("ok_error", 64'(error_o), 64'd0);
      res_addr_i = 3'd5; tick();
      chk("ok_read5", 64'(res_rdata_o), 64'h1A005);

      // ---- overflow: 9 pushes, 9th dropped ----
      launch();
      for (int k = 0; k < S; k++) push(17'h1B000 + 17'(k), 1'b0);
      chk("ovf_err_before", 64'(error_o), 64'd0);
      push(17'h1FFFF, 1'b0);
      chk("ovf_err_set", 64'(error_o), 64'd1);
      mm_done_i = 1'b1; tick(); mm_done_i = 1'b0;
      chk("ovf_done_pulse", 64'(done_o), 64'd1);
      tick();
      chk("ovf_err_sticky", 64'(error_o), 64'd1);
      res_addr_i = 3'd0; tick();
      chk("ovf_read0", 64'(res_rdata_o), 64'h1B000);
      res_addr_i = 3'd7; tick();
      chk("ovf_read7", 64'(res_rdata_o), 64'h1B007);

      // ---- short run: done after 6 pushes; start clears the error ----
      start_i = 1'b1; tick(); start_i = 1'b0;
      chk("start_clears_err", 64'(error_o), 64'd0);
      tick();
      for (int k = 0; k < 6; k++) push(17'h1C000 + 17'(k), 1'b0);
      mm_done_i = 1'b1; tick(); mm_done_i = 1'b0;
      chk("short_done_pulse", 64'(done_o), 64'd1);
      chk("short_err", 64'(error_o), 64'd1);
      tick();

      // ---- last push coincides with done: the word counts ----
      launch();
      for (int k = 0; k < 7; k++) push(17'h1D000 + 17'(k), 1'b0);
      push(17'h1D007, 1'b1);
      chk("coinc_done_pulse", 64'(done_o), 64'd1);
      chk("coinc_err", 64'(error_o), 64'd0);
      tick();
      res_addr_i = 3'd7; tick();
      chk("coinc_read7", 64'(res_rdata_o), 64'h1D007);

      // ---- reset in the middle of RUN ----
      launch();
      a_shift_i = 1'b1; b_fetch_i = 1'b1; p_fetch_i = 1'b1; tick();
      a_shift_i = 1'b0; b_fetch_i = 1'b0; p_fetch_i = 1'b0;
      chk("mid_b_before_rst", 64'(b_o), 64'h200);
      reset_i = 1'b1; tick(); reset_i = 1'b0;
      chk("mid_rst_busy", 64'(busy_o), 64'd0);
      chk("mid_rst_a", 64'(a_o), 64'd0);
      chk("mid_rst_b", 64'(b_o), 64'd0);
      chk("mid_rst_p", 64'(p_o), 64'd0);
      chk("mid_rst_done", 64'(done_o), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("mid_rst_no_done%0d", i), 64'(done_o), 64'd0);
      end
      // fetch outside RUN is ignored
      b_fetch_i = 1'b1; tick(); b_fetch_i = 1'b0;
      chk("idle_fetch_ignored", 64'(b_o), 64'd0);
      // memories retained, busy write earlier had no effect
      start_i = 1'b1; tick(); start_i = 1'b0;
      chk("retain_mm_start", 64'(mm_start_o), 64'd1);
      chk("retain_a_win0", 64'(a_o), 64'({17'h102, 17'h101, 17'h100}));
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
